// File: rtl/fifo_uart_tx_pkg.sv
// Package: fifo_uart_pkg
// Shared definitions for the FIFO-fed UART transmitter: the FSM state encodings,
// the default bit period and the idle line level.
// Optional feature macro: PARITY_EN adds the PARITY state, which inserts an even-parity bit.
package fifo_uart_pkg;

    localparam int       DEF_CLKS_PER_BIT = 16;
    localparam logic     IDLE_LEVEL       = 1'b1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_POP    = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_START  = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
`ifdef PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd5;
`endif
    localparam logic [2:0] ST_STOP   = 3'd6;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        POP    = ST_POP,
        LOAD   = ST_LOAD,
        START  = ST_START,
        DATA   = ST_DATA,
`ifdef PARITY_EN
        PARITY = ST_PARITY,
`endif
        STOP   = ST_STOP
    } state_t;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Interface: fifo_uart_tx_if
// Read-side handshake between syn_fifo and its consumer.
//   fifo_empty : FIFO empty flag        (FIFO -> consumer)
//   fifo_dout  : FIFO read data, valid the cycle after fifo_ren (FIFO -> consumer)
//   fifo_ren   : one-cycle pop strobe    (consumer -> FIFO)
// master = consumer (fifo_uart_tx); slave = FIFO.
interface fifo_uart_tx_if #(
    parameter int DATA_W = 8
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_ren;

    modport master (output fifo_ren, input fifo_empty, input fifo_dout);
    modport slave  (input fifo_ren, output fifo_empty, output fifo_dout);
endinterface

// File: rtl/fifo_uart_tx_baud_tick.sv
// Module: baud_tick
// Bit-period counter for the UART transmitter. It counts 0..CLKS_PER_BIT-1 and wraps.
//   clk      : clock
//   reset    : synchronous active-low reset
//   clear    : forces the counter to 0 on the next edge so that a bit period starts
//   bit_end  : high in the last cycle of each bit period
//   near_end : high one cycle before bit_end, used to register end-of-bit outputs early
module baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end,
    output logic near_end
);
    localparam int             CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  PRE  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_end  = (cnt == LAST);
    assign near_end = (cnt == PRE);
endmodule

// File: rtl/fifo_uart_tx.sv
// Module: fifo_uart_tx
// This module pops bytes from syn_fifo whenever the FIFO is non-empty. It sends each byte
// LSB-first on the tx line as a start bit, DATA_W data bits, an optional parity bit and a
// stop bit.
//   clk       : clock
//   reset     : synchronous active-low reset
//   fifo      : fifo_uart_tx_if.master (fifo_empty, fifo_dout in; fifo_ren out)
//   tx        : serial line, idles high
//   busy      : high from the pop through the end of the stop bit
//   byte_done : one-cycle pulse in the last cycle of the stop bit
// Optional feature macro: PARITY_EN inserts an even-parity bit between the data bits
// and the stop bit.
//
// state  | meaning
// IDLE   | line idle, wait for fifo_empty=0
// POP    | fifo_ren high for this one cycle
// LOAD   | capture fifo_dout, restart bit timer
// START  | tx=0 for one bit period
// DATA   | shift out DATA_W bits LSB-first
// PARITY | even parity of the byte (PARITY_EN only)
// STOP   | tx=1 for one bit period; then pop again or go idle
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_W       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    fifo_uart_tx_if.master        fifo,
    output logic                  tx,
    output logic                  busy,
    output logic                  byte_done
);
    localparam int            BW       = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_t            state;
    logic [DATA_W-1:0] shift;
    logic [BW-1:0]     bit_cnt;
    logic              bit_end;
    logic              near_end;
    logic              baud_clr;
`ifdef PARITY_EN
    logic              par;
`endif

    // Restarting the timer in LOAD aligns every later state to whole bit periods.
    assign baud_clr = (state == LOAD);

    baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .reset    (reset),
        .clear    (baud_clr),
        .bit_end  (bit_end),
        .near_end (near_end)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            tx            <= IDLE_LEVEL;
            fifo.fifo_ren <= 1'b0;
            busy          <= 1'b0;
            byte_done     <= 1'b0;
            shift         <= '0;
            bit_cnt       <= '0;
`ifdef PARITY_EN
            par           <= 1'b0;
`endif
        end else begin
            fifo.fifo_ren <= 1'b0;
            // byte_done is registered, so it is raised one cycle early.
            byte_done     <= (state == STOP) && near_end;
            case (state)
                IDLE: begin
                    tx <= IDLE_LEVEL;
                    if (!fifo.fifo_empty) begin
                        state         <= POP;
                        fifo.fifo_ren <= 1'b1;
                        busy          <= 1'b1;
                    end
                end
                POP: begin
                    state <= LOAD;
                end
                LOAD: begin
                    shift   <= fifo.fifo_dout;
                    bit_cnt <= '0;
`ifdef PARITY_EN
                    par     <= ^fifo.fifo_dout;
`endif
                    tx      <= 1'b0;
                    state   <= START;
                end
                START: begin
                    if (bit_end) begin
                        tx    <= shift[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
`ifdef PARITY_EN
                            tx    <= par;
                            state <= PARITY;
`else
                            tx    <= IDLE_LEVEL;
                            state <= STOP;
`endif
                        end else begin
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        tx    <= IDLE_LEVEL;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        // Back-to-back frames: the next pop follows straight on with no idle bit.
                        if (!fifo.fifo_empty) begin
                            state         <= POP;
                            fifo.fifo_ren <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= IDLE_LEVEL;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx with CLKS_PER_BIT=4. A queue models syn_fifo with a 1-cycle
// read latency. Every byte pushed into the FIFO is also pushed into an expected queue.
// A line monitor decodes tx frames on its own and checks each frame against that queue.
module tb_fifo_uart_tx;
    localparam int CPB = 4;
    localparam int DW  = 8;
`ifdef PARITY_EN
    localparam int NB  = 11;
`else
    localparam int NB  = 10;
`endif
    localparam int FRAME = NB * CPB + 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tx, busy, byte_done;

    fifo_uart_tx_if #(.DATA_W(DW)) fif ();

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .fifo      (fif),
        .tx        (tx),
        .busy      (busy),
        .byte_done (byte_done)
    );

    always #5 clk = ~clk;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int         starts[$];
    int n_pass = 0;
    int n_total = 0;
    int ren_cnt = 0;
    int done_cnt = 0;
    int cycle = 0;
    int pushed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        exp_q.push_back(b);
        pushed++;
    endtask

    // syn_fifo model: the data from a pop appears on the next cycle, and empty is registered.
    always @(posedge clk) begin
        if (fif.fifo_ren && fifo_q.size() > 0) fif.fifo_dout <= fifo_q.pop_front();
        fif.fifo_empty <= (fifo_q.size() == 0);
    end

    task automatic frame_check(input logic [NB-1:0] b);
        logic [7:0]    d;
        logic [NB-1:0] e;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_frame: got frame %0h expected no frame", b);
        end else begin
            d = exp_q.pop_front();
`ifdef PARITY_EN
            e = {1'b1, 1'($countones(d) % 2), d, 1'b0};
`else
            e = {1'b1, d, 1'b0};
`endif
            check("frame_bits", 32'(b), 32'(e));
        end
    endtask

    // The line monitor samples each bit in the middle of its period, counting from the falling edge of the start bit.
    logic          in_frame = 1'b0;
    int            cyc = 1000000;
    logic [NB-1:0] bits;
    always @(negedge clk) begin
        cycle++;
        if (!reset) begin
            in_frame = 1'b0;
            cyc = 1000000;
        end else begin
            cyc++;
            if (!in_frame && tx == 1'b0) begin
                in_frame = 1'b1;
                cyc = 0;
                starts.push_back(cycle);
            end
            if (in_frame && (cyc % CPB) == CPB / 2) begin
                bits = {tx, bits[NB-1:1]};
                if (cyc / CPB == NB - 1) begin
                    in_frame = 1'b0;
                    frame_check(bits);
                end
            end
            if (fif.fifo_ren === 1'b1) begin
                ren_cnt++;
                check("ren_when_nonempty", 32'(fifo_q.size() > 0), 32'(1));
            end
            if (byte_done === 1'b1) begin
                done_cnt++;
                check("byte_done_timing", 32'(cyc), 32'(NB * CPB - 1));
            end
        end
    end

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt < target) begin
            n_total++;
            $display("FAIL wait_byte_done: got %0d expected %0d", done_cnt, target);
        end
    endtask

    initial begin
        int s0, bad, n, len, d0;

        // Reset held with the FIFO non-empty
        reset = 1'b0;
        push(8'hA5);
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", 32'({tx, fif.fifo_ren, busy}), 32'(3'b100));
        end

        // Single byte
        reset = 1'b1;
        wait_done(1, FRAME + 20);
        repeat (4) @(negedge clk);
        check("single_busy_low", 32'(busy), 32'(0));
        check("single_tx_idle", 32'(tx), 32'(1));
        check("single_ren_count", 32'(ren_cnt), 32'(1));
        repeat (20) @(negedge clk);
        check("single_no_second_ren", 32'(ren_cnt), 32'(1));

        // Three bytes back to back
        s0 = starts.size();
        push(8'h0A); push(8'h08); push(8'h05);
        wait_done(4, 3 * FRAME + 20);
        repeat (4) @(negedge clk);
        check("b2b_ren_count", 32'(ren_cnt), 32'(4));
        check("b2b_frame_count", 32'(starts.size() - s0), 32'(3));
        if (starts.size() - s0 >= 3) begin
            check("b2b_gap_1", 32'(starts[s0+1] - starts[s0]), 32'(FRAME));
            check("b2b_gap_2", 32'(starts[s0+2] - starts[s0+1]), 32'(FRAME));
        end

        // Idle with the FIFO empty
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if ({tx, fif.fifo_ren, busy} !== 3'b100) bad++;
        end
        check("idle_violations", 32'(bad), 32'(0));

        // Reset during data bit 3
        push(8'hFF);
        n = 0;
        while (tx !== 1'b0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("abort_start_seen", 32'(tx), 32'(0));
        repeat (4 * CPB + 1) @(negedge clk);
        reset = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        check("abort_outputs", 32'({tx, fif.fifo_ren, busy}), 32'(3'b100));
        push(8'h3C);
        @(negedge clk);
        reset = 1'b1;
        d0 = done_cnt;
        wait_done(d0 + 1, FRAME + 20);

        // Randomised bursts, starting with bytes of odd and even parity
        push(8'h07); push(8'h03);
        repeat (4) begin
            repeat ($urandom_range(0, 2 * FRAME)) @(negedge clk);
            len = $urandom_range(1, 3);
            repeat (len) push(8'($urandom_range(0, 255)));
        end
        n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < 20 * FRAME) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check("exp_queue_drained", 32'(exp_q.size()), 32'(0));
        check("ren_total", 32'(ren_cnt), 32'(pushed));
        check("done_total", 32'(done_cnt), 32'(pushed - 1));
        check("final_idle", 32'({tx, busy}), 32'(2'b10));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
